shift_seq: RTL and testbench

// - Multi-cycle sequential shift unit: one bit position per clock, start/busy/done handshake.
// - Executes the ALU shift opcodes SLL, SLR (rotate left), SRL and SRA on 16-bit operands.
// - Produces the full condition code {s,z,c,v} (sign, zero, carry, overflow) for the ALU flag register.
// - Used where the area of a full barrel shifter is not justified, e.g. the low-area datapath variant.

---
 rtl/shift_seq_pkg.sv | 34 +++
 rtl/shift_seq_if.sv | 18 +
 rtl/shift_seq_step.sv | 43 ++++
 rtl/shift_seq.sv | 105 ++++++++++
 tb/tb_shift_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the sequential shifter: opcodes, FSM states and
// the effective-amount helper used on the accept edge.
package shift_seq_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    // Opcodes shared with the ALU decoder and the barrel shifter
    localparam logic [3:0] F_SLL = 4'b1000;
    localparam logic [3:0] F_SLR = 4'b1001;
    localparam logic [3:0] F_SRL = 4'b1010;
    localparam logic [3:0] F_SRA = 4'b1011;

    localparam logic [3:0] CODE_RST = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    // Rotates wrap mod 16; linear shifts saturate at 16; unsupported opcodes do nothing
    function automatic logic [CNT_W-1:0] eff_amount(input logic [3:0] fcode,
                                                    input logic [CNT_W-1:0] shift);
        logic [CNT_W-1:0] amt;
        case (fcode)
            F_SLR:               amt = {1'b0, shift[3:0]};
            F_SLL, F_SRL, F_SRA: amt = (shift > 5'd16) ? 5'd16 : shift;
            default:             amt = 5'd0;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request/response bundle of the sequential shifter.
interface shift_seq_if;
    import shift_seq_pkg::*;

    logic             start;
    logic [3:0]       fcode;
    logic [CNT_W-1:0] shift;
    logic [WIDTH-1:0] in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       code;

    modport master (output start, fcode, shift, in,
                    input  busy, done, result, code);
    modport slave  (input  start, fcode, shift, in,
                    output busy, done, result, code);
endinterface

// File: rtl/shift_seq_step.sv
// Combinational one-bit shift step: next value, the bit shifted out and the
// left-shift sign-change indication.
module shift_step
    import shift_seq_pkg::*;
(
    input  logic [3:0]       fcode,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_next,
    output logic             out_bit,
    output logic             ovf_bit
);

    // One-position shift selected by opcode; unknown opcodes pass through
    always_comb begin
        r_next  = r;
        out_bit = 1'b0;
        ovf_bit = 1'b0;
        case (fcode)
            F_SLL: begin
                r_next  = {r[WIDTH-2:0], 1'b0};
                out_bit = r[WIDTH-1];
                ovf_bit = r[WIDTH-1] ^ r[WIDTH-2];
            end
            F_SLR: begin
                r_next  = {r[WIDTH-2:0], r[WIDTH-1]};
                out_bit = r[WIDTH-1];
            end
            F_SRL: begin
                r_next  = {1'b0, r[WIDTH-1:1]};
                out_bit = r[0];
            end
            F_SRA: begin
                r_next  = {r[WIDTH-1], r[WIDTH-1:1]};
                out_bit = r[0];
            end
            default: begin
                r_next  = r;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: one bit per RUN cycle, start/busy/done handshake and
// the {s,z,c,v} condition code for the ALU flag register.
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    shift_seq_if.slave  bus
);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       fcode_r;
    logic [WIDTH-1:0] work_r;
    logic             c_r;
    logic             v_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       code_r;
    logic             accept_s;
    logic [WIDTH-1:0] step_s;
    logic             out_bit_s;
    logic             ovf_bit_s;

    shift_step u_step (
        .fcode   (fcode_r),
        .r       (work_r),
        .r_next  (step_s),
        .out_bit (out_bit_s),
        .ovf_bit (ovf_bit_s)
    );

    assign accept_s = bus.start && ((state_r == IDLE) || (state_r == FIN));

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (cnt_r == {CNT_W{1'b0}}) state_s = FIN;
                else                        state_s = RUN;
            end
            FIN: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == FIN);
        end
    end

    // Operand capture, bit-serial stepping and flag accumulation; the visible
    // result/code only update when an operation finishes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            fcode_r  <= 4'b0000;
            work_r   <= {WIDTH{1'b0}};
            c_r      <= 1'b0;
            v_r      <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            code_r   <= CODE_RST;
        end else if (accept_s) begin
            cnt_r   <= eff_amount(bus.fcode, bus.shift);
            fcode_r <= bus.fcode;
            work_r  <= bus.in;
            c_r     <= 1'b0;
            v_r     <= 1'b0;
        end else if (state_r == RUN) begin
            if (cnt_r != {CNT_W{1'b0}}) begin
                cnt_r  <= cnt_r - 5'd1;
                work_r <= step_s;
                c_r    <= out_bit_s;
                v_r    <= v_r | ovf_bit_s;
            end else begin
                result_r <= work_r;
                code_r   <= {work_r[WIDTH-1], (work_r == {WIDTH{1'b0}}), c_r, v_r};
            end
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.code   = code_r;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: the driver pushes model predictions, a
// negedge monitor pops and compares them whenever done pulses.
module tb_shift_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  code;
        int          acc;
        int          n;
    } exp_t;

    exp_t exp_q[$];

    shift_seq_if bus ();

    shift_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from the opcode definitions, using whole-word arithmetic
    function automatic void model(input logic [3:0] f, input logic [4:0] s, input logic [15:0] d,
                                  output logic [15:0] res, output logic [3:0] code, output int n);
        logic [31:0] wide;
        longint      prod;
        int          sd;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        res = d;
        n = 0;
        case (f)
            4'b1000: begin
                n = (s > 5'd16) ? 16 : int'(s);
                wide = {16'h0000, d} << n;
                res = wide[15:0];
                c = (n != 0) && wide[16];
                prod = longint'($signed(d)) * (longint'(1) << n);
                v = (prod > 32767) || (prod < -32768);
            end
            4'b1001: begin
                n = int'(s[3:0]);
                wide = {d, d} << n;
                res = wide[31:16];
                c = (n != 0) && res[0];
            end
            4'b1010: begin
                n = (s > 5'd16) ? 16 : int'(s);
                res = d >> n;
                c = (n != 0) && d[n-1];
            end
            4'b1011: begin
                n = (s > 5'd16) ? 16 : int'(s);
                sd = int'($signed(d));
                sd = sd >>> n;
                res = sd[15:0];
                c = (n != 0) && d[n-1];
            end
            default: n = 0;
        endcase
        code = {res[15], (res == 16'h0000), c, v};
    endfunction

    task automatic drive(input logic [3:0] f, input logic [4:0] s, input logic [15:0] d);
        exp_t e;
        bus.fcode = f;
        bus.shift = s;
        bus.in    = d;
        bus.start = 1'b1;
        model(f, s, d, e.res, e.code, e.n);
        e.acc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [3:0] f, input logic [4:0] s, input logic [15:0] d);
        drive(f, s, d);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
    endtask

    // Monitor: pops one prediction per done pulse and checks timing and values
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.busy) busy_cnt++;
            check("busy_done_exclusive", {31'd0, bus.busy & bus.done}, 32'd0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {16'd0, bus.result}, {16'd0, e.res});
                    check("code", {28'd0, bus.code}, {28'd0, e.code});
                    check("done_cycle", cyc, e.acc + e.n + 1);
                    check("busy_cycles", busy_cnt, e.n + 1);
                end
                busy_cnt = 0;
            end
        end else begin
            busy_cnt = 0;
        end
    end

    initial begin
        int dn;
        logic [3:0] f;
        bus.start = 1'b0;
        bus.fcode = 4'b0000;
        bus.shift = 5'd0;
        bus.in    = 16'h0000;

        #1 rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", {16'd0, bus.result}, 32'd0);
        check("rst_code", {28'd0, bus.code}, 32'h4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op(4'b1000, 5'd1, 16'h4001);
        run_op(4'b1011, 5'd4, 16'h8000);
        repeat (2) @(negedge clk);
        run_op(4'b1001, 5'd17, 16'h8001);
        run_op(4'b1010, 5'd16, 16'hFFFF);
        @(negedge clk);
        run_op(4'b0000, 5'd0, 16'h1234);
        run_op(4'b1000, 5'd0, 16'h1234);
        run_op(4'b1000, 5'd31, 16'hFFFF);
        run_op(4'b1011, 5'd20, 16'h7FFF);

        // start pulsed mid-RUN must be ignored
        drive(4'b1010, 5'd10, 16'hA5A5);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.fcode = 4'b1000;
        bus.shift = 5'd2;
        bus.in    = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // start held through FIN gives back-to-back operations
        drive(4'b1000, 5'd3, 16'h0F0F);
        wait_done();
        drive(4'b1001, 5'd5, 16'h8421);
        wait_done();
        drive(4'b1011, 5'd0, 16'hC000);
        wait_done();
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // asynchronous reset between edges in the middle of RUN
        drive(4'b1000, 5'd10, 16'h1357);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_result", {16'd0, bus.result}, 32'd0);
        check("abort_code", {28'd0, bus.code}, 32'h4);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("no_done_after_abort", dn, 0);
        run_op(4'b1010, 5'd3, 16'h8000);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 4) f = 4'($urandom_range(0, 15));
            else f = 4'b1000 | 4'($urandom_range(0, 3));
            run_op(f, 5'($urandom_range(0, 31)), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
